decoder_2to4_seq: RTL

DECODER_2TO4_SEQ -- requirements
Module: decoder_2to4_seq

---
 rtl/decoder_2to4_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/decoder_2to4_seq.sv
// Queued 2-to-4 decoder: accepted {en, code} pairs pass through a small FIFO,
// and each pair drives a one-hot slot on out_y for HOLD_CYCLES cycles.
module decoder_2to4_seq #(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [1:0]                    in_code,
   input  logic                          in_en,
   output logic [3:0]                    out_y,
   output logic                          out_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic {
      IDLE,
      HOLD
   } state_e;

   logic [2:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    hold_cnt_q, hold_cnt_d;
   logic [3:0]    y_q, y_d;
   logic          valid_q, valid_d;
   state_e        state_q, state_d;

   logic          push;
   logic          pop;
   logic [2:0]    head;

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
   assign in_ready   = rst_n && (count_q < DEPTH_C);
   assign push       = in_valid && in_ready;
   assign pop        = (count_q != '0) && ((state_q == IDLE) || (hold_cnt_q == '0));
   assign head       = mem_q[rd_ptr_q];

   assign out_y      = y_q;
   assign out_valid  = valid_q;
   assign fifo_count = count_q;
   assign busy       = (state_q == HOLD) || (count_q != '0);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      hold_cnt_d = hold_cnt_q;
      y_d        = y_q;
      valid_d    = valid_q;
      state_d    = state_q;

      if (push) begin
         wr_ptr_d = PW'(wr_ptr_q + 1'b1);
      end
      if (pop) begin
         rd_ptr_d = PW'(rd_ptr_q + 1'b1);
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end

      if (pop) begin
         state_d    = HOLD;
         hold_cnt_d = HOLD_LOAD;
         valid_d    = 1'b1;
         y_d        = head[2] ? (4'b0001 << head[1:0]) : '0;
      end else if (state_q == HOLD) begin
         if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
         end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            y_d     = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         hold_cnt_q <= '0;
         y_q        <= '0;
         valid_q    <= 1'b0;
         state_q    <= IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         hold_cnt_q <= hold_cnt_d;
         y_q        <= y_d;
         valid_q    <= valid_d;
         state_q    <= state_d;
      end
   end

   // Storage needs no reset: an entry is only read after the pointers say it was written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_en, in_code};
      end
   end

endmodule
